// File: rtl/atconv_sched.sv
// Job sequencer for the conv/pool engines and arbiter for the shared layer-memory port.
// Bus requests reach the memory one cycle after they are made; pool reads return data two cycles after the grant.
// A pool write always beats a simultaneous pool read, and the pool engine holds its read until it is granted.
module atconv_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        busy,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        pool_start,
    input  logic        pool_done,
    input  logic        conv_cwr,
    input  logic [11:0] conv_caddr,
    input  logic [12:0] conv_cdata,
    input  logic        pool_crd,
    input  logic        pool_cwr,
    input  logic [11:0] pool_raddr,
    input  logic [9:0]  pool_waddr,
    input  logic [12:0] pool_cdata,
    output logic        pool_rgnt,
    output logic        pool_rvalid,
    output logic [12:0] pool_rdata,
    output logic        cwr,
    output logic        crd,
    output logic [11:0] caddr_wr,
    output logic [11:0] caddr_rd,
    output logic [12:0] cdata_wr,
    input  logic [12:0] cdata_rd,
    output logic        csel,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CONV, POOL, FINISH} state_t;

    state_t      state, state_nxt;
    logic        job_go, conv_end, pool_end;
    logic        conv_wr_fwd, pool_wr_fwd;
    logic [12:0] wr0;
    logic [10:0] wr1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        job_go      = 1'b0;
        conv_end    = 1'b0;
        pool_end    = 1'b0;
        conv_wr_fwd = 1'b0;
        pool_wr_fwd = 1'b0;
        pool_rgnt   = 1'b0;
        case (state)
            IDLE: begin
                job_go = ready;
                if (ready) state_nxt = CONV;
            end
            CONV: begin
                conv_wr_fwd = conv_cwr;
                conv_end    = conv_done;
                if (conv_done) state_nxt = POOL;
            end
            POOL: begin
                pool_wr_fwd = pool_cwr;
                pool_rgnt   = pool_crd & ~pool_cwr;
                pool_end    = pool_done;
                if (pool_done) state_nxt = FINISH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CONV) || (state == POOL);

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_start <= 1'b0;
            pool_start <= 1'b0;
            wr0        <= '0;
            wr1        <= '0;
            err        <= 1'b0;
        end else begin
            conv_start <= job_go;
            pool_start <= conv_end;
            if (job_go) begin
                wr0 <= '0;
                wr1 <= '0;
                err <= 1'b0;
            end else begin
                if (conv_wr_fwd) wr0 <= wr0 + 13'd1;
                if (pool_wr_fwd) wr1 <= wr1 + 11'd1;
                // Count is checked as it stands when done arrives; sticky until the next job starts.
                if ((conv_end && wr0 != 13'd4096) || (pool_end && wr1 != 11'd1024))
                    err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= 1'b0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
        end else begin
            cwr <= conv_wr_fwd | pool_wr_fwd;
            crd <= pool_rgnt;
            if (conv_wr_fwd) begin
                csel     <= 1'b0;
                caddr_wr <= conv_caddr;
                cdata_wr <= conv_cdata;
            end else if (pool_wr_fwd) begin
                csel     <= 1'b1;
                caddr_wr <= {2'b00, pool_waddr};
                cdata_wr <= pool_cdata;
            end else if (pool_rgnt) begin
                csel     <= 1'b0;
                caddr_rd <= pool_raddr;
            end
        end
    end

    // Memory data is valid at the edge closing the crd cycle, so capture keys off crd itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_rvalid <= 1'b0;
            pool_rdata  <= '0;
        end else begin
            pool_rvalid <= crd;
            if (crd) pool_rdata <= cdata_rd;
        end
    end

endmodule

// File: tb/tb_atconv_sched.sv
// Directed bench for atconv_sched: job sequencing, bus forwarding, read pipeline, write-count error, reset.
module tb_atconv_sched;

    logic        clk = 1'b0;
    logic        reset, ready, conv_done, pool_done;
    logic        conv_cwr, pool_crd, pool_cwr;
    logic [11:0] conv_caddr, pool_raddr;
    logic [9:0]  pool_waddr;
    logic [12:0] conv_cdata, pool_cdata, cdata_rd;
    logic        busy, conv_start, pool_start, pool_rgnt, pool_rvalid;
    logic [12:0] pool_rdata, cdata_wr;
    logic        cwr, crd, csel, err;
    logic [11:0] caddr_wr, caddr_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: one known word, everything else returns its own address.
    assign cdata_rd = (caddr_rd == 12'h040) ? 13'h1F0 : {1'b0, caddr_rd};

    atconv_sched dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .conv_start(conv_start), .conv_done(conv_done),
        .pool_start(pool_start), .pool_done(pool_done),
        .conv_cwr(conv_cwr), .conv_caddr(conv_caddr), .conv_cdata(conv_cdata),
        .pool_crd(pool_crd), .pool_cwr(pool_cwr), .pool_raddr(pool_raddr),
        .pool_waddr(pool_waddr), .pool_cdata(pool_cdata),
        .pool_rgnt(pool_rgnt), .pool_rvalid(pool_rvalid), .pool_rdata(pool_rdata),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd), .csel(csel), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ready = 0; conv_done = 0; pool_done = 0;
        conv_cwr = 0; pool_crd = 0; pool_cwr = 0;
        conv_caddr = 0; conv_cdata = 0; pool_raddr = 0; pool_waddr = 0; pool_cdata = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_cwr", cwr, 0);
        chk("rst_crd", crd, 0);
        chk("rst_err", err, 0);
        chk("rst_rvalid", pool_rvalid, 0);
        chk("rst_caddr_wr", caddr_wr, 0);
        chk("rst_rdata", pool_rdata, 0);

        // Job 1: short directed job
        reset = 0; ready = 1;
        tick();
        chk("j1_busy", busy, 1);
        chk("j1_conv_start", conv_start, 1);
        ready = 0;
        tick();
        chk("j1_conv_start_low", conv_start, 0);
        chk("j1_busy_hold", busy, 1);

        conv_cwr = 1; conv_caddr = 12'h123; conv_cdata = 13'h0AB;
        tick();
        conv_cwr = 0;
        chk("cw_cwr", cwr, 1);
        chk("cw_csel", csel, 0);
        chk("cw_addr", caddr_wr, 12'h123);
        chk("cw_data", cdata_wr, 13'h0AB);
        chk("cw_crd", crd, 0);

        pool_crd = 1; pool_cwr = 1; pool_waddr = 10'h2AA;
        #1;
        chk("ign_rgnt", pool_rgnt, 0);
        tick();
        pool_crd = 0; pool_cwr = 0;
        chk("ign_cwr", cwr, 0);
        chk("ign_crd", crd, 0);

        conv_done = 1;
        tick();
        conv_done = 0;
        chk("j1_pool_start", pool_start, 1);
        chk("j1_err_short", err, 1);

        pool_crd = 1; pool_cwr = 1; pool_waddr = 10'h3FF; pool_raddr = 12'h040; pool_cdata = 13'h155;
        #1;
        chk("coll_rgnt", pool_rgnt, 0);
        tick();
        pool_cwr = 0;
        chk("coll_cwr", cwr, 1);
        chk("coll_csel", csel, 1);
        chk("coll_addr", caddr_wr, 12'h3FF);
        chk("coll_data", cdata_wr, 13'h155);
        chk("coll_crd", crd, 0);
        chk("pool_start_low", pool_start, 0);

        #1;
        chk("rd_rgnt", pool_rgnt, 1);
        tick();
        pool_crd = 0;
        chk("rd_crd", crd, 1);
        chk("rd_csel", csel, 0);
        chk("rd_addr", caddr_rd, 12'h040);
        chk("rd_cwr", cwr, 0);
        chk("rd_rvalid_n1", pool_rvalid, 0);
        tick();
        chk("rd_rvalid_n2", pool_rvalid, 1);
        chk("rd_rdata", pool_rdata, 13'h1F0);
        chk("rd_crd_low", crd, 0);
        tick();
        chk("rd_rvalid_n3", pool_rvalid, 0);
        chk("rd_rdata_hold", pool_rdata, 13'h1F0);

        pool_done = 1;
        tick();
        pool_done = 0;
        chk("j1_finish_busy", busy, 0);
        tick();
        chk("j1_idle_busy", busy, 0);
        chk("j1_err_sticky", err, 1);

        // Job 2: exact counts, no error
        ready = 1;
        tick();
        ready = 0;
        chk("j2_conv_start", conv_start, 1);
        chk("j2_err_clear", err, 0);
        for (int i = 0; i < 4096; i++) begin
            conv_cwr = 1; conv_caddr = i[11:0]; conv_cdata = i[12:0];
            tick();
        end
        conv_cwr = 0;
        chk("j2_last_addr", caddr_wr, 12'hFFF);
        conv_done = 1;
        tick();
        conv_done = 0;
        chk("j2_err_conv", err, 0);
        chk("j2_pool_start", pool_start, 1);
        for (int i = 0; i < 1024; i++) begin
            pool_cwr = 1; pool_waddr = i[9:0]; pool_cdata = 13'h1000;
            tick();
        end
        pool_cwr = 0;
        pool_done = 1;
        tick();
        pool_done = 0;
        chk("j2_busy_fall", busy, 0);
        chk("j2_err_pool", err, 0);
        // ready held high from here restarts from IDLE
        ready = 1;
        tick();
        chk("j2_idle", busy, 0);
        tick();
        chk("j3_conv_start", conv_start, 1);
        tick();
        chk("j3_ready_ignored", conv_start, 0);
        ready = 0;

        // Job 3: one conv write short (one write already made above is absent; do 4095 here)
        for (int i = 0; i < 4095; i++) begin
            conv_cwr = 1; conv_caddr = i[11:0]; conv_cdata = 13'h0001;
            tick();
        end
        conv_cwr = 0;
        chk("j3_err_before", err, 0);
        conv_done = 1;
        tick();
        conv_done = 0;
        chk("j3_err_4095", err, 1);

        // Reset with a read in flight
        pool_crd = 1; pool_raddr = 12'h040;
        tick();
        pool_crd = 0;
        chk("rr_crd", crd, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rr_busy", busy, 0);
        chk("rr_crd_low", crd, 0);
        chk("rr_rvalid", pool_rvalid, 0);
        chk("rr_err", err, 0);
        chk("rr_caddr_rd", caddr_rd, 0);
        tick();
        chk("rr_rvalid_after", pool_rvalid, 0);
        chk("rr_rdata", pool_rdata, 0);
        chk("rr_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
